// File: rtl/opsum_drain_arb_pkg.sv
// opsum_drain_arb_pkg
// Shared definitions for the opsum drain arbiter:
//   - NUM_FIFO_DEF / CNT_W_DEF : default FIFO count and tile word counter width
//   - DATA_W                   : width of one drained output word
//   - state_e                  : drain FSM state encoding
package opsum_drain_arb_pkg;

  localparam int NUM_FIFO_DEF = 4;
  localparam int CNT_W_DEF    = 16;
  localparam int DATA_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_ARB  = 3'd2,
    ST_CAP  = 3'd3,
    ST_SEND = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/opsum_drain_arb_rr.sv
// rr_arbiter
// Round-robin grant: the search starts at ptr_i and wraps, lowest offset wins.
// Ports:
//   req_i       : request vector, one bit per requester
//   ptr_i       : index that has highest priority this cycle
//   gnt_o       : one-hot grant (all zero when no request)
//   gnt_idx_o   : binary index of the granted requester
//   gnt_valid_o : at least one request was granted
// N must be a power of two so the rotated index wraps by plain truncation.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  // rot_req[i] is the request of the requester i positions after the pointer.
  logic [N-1:0]     rot_req;
  logic [IDX_W-1:0] rot_idx [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot_idx[gi] = ptr_i + IDX_W'(gi);
      assign rot_req[gi] = req_i[rot_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the smallest offset is the one left standing.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = rot_idx[i];
      end
    end
    if (gnt_valid_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/opsum_drain_arb.sv
// opsum_drain_arb
// Drains a tile of output words from NUM_FIFO opsum FIFOs, round-robin, onto a
// single valid/ready word stream.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start_i                  : start a tile (ignored unless idle)
//   pack32_i, tile_words_i   : pop width and tile length, sampled on start
//   fifo_full_i/empty_i      : per-FIFO status flags
//   fifo_data_i              : per-FIFO registered pop data, FIFO k at [32k+31:32k]
//   fifo_pop_en_o            : one-hot pop strobe
//   fifo_pop_mod_o           : pop width to all FIFOs (latched pack32)
//   fifo_reset_o             : one-cycle synchronous clear at tile start
//   out_valid_o/ready_i      : downstream handshake
//   out_data_o, out_src_o    : word and the FIFO it came from
//   busy_o, done_o           : tile in progress, tile-complete pulse
//   stall_cnt_o              : only with OPSUM_DRAIN_ARB_PERF_EN; saturating count of
//                              SEND cycles where the consumer was not ready
module opsum_drain_arb
  import opsum_drain_arb_pkg::*;
#(
  parameter int NUM_FIFO = NUM_FIFO_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         pack32_i,
  input  logic [CNT_W-1:0]             tile_words_i,
  input  logic [NUM_FIFO-1:0]          fifo_full_i,
  input  logic [NUM_FIFO-1:0]          fifo_empty_i,
  input  logic [NUM_FIFO*DATA_W-1:0]   fifo_data_i,
  output logic [NUM_FIFO-1:0]          fifo_pop_en_o,
  output logic                         fifo_pop_mod_o,
  output logic                         fifo_reset_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_W-1:0]            out_data_o,
  output logic [$clog2(NUM_FIFO)-1:0]  out_src_o,
  output logic                         busy_o,
  output logic                         done_o
`ifdef OPSUM_DRAIN_ARB_PERF_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_FIFO);

  state_e             state_q, state_d;
  logic               pack32_q, pack32_d;
  logic [CNT_W-1:0]   tile_q, tile_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [NUM_FIFO-1:0] elig;
  logic [NUM_FIFO-1:0] gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_valid;
  logic [DATA_W-1:0]   fifo_word [NUM_FIFO];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIFO; gi++) begin : g_word
      assign fifo_word[gi] = fifo_data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A 32-bit pop needs two 16-bit entries, so only a full FIFO qualifies.
  assign elig = pack32_q ? fifo_full_i : ~fifo_empty_i;

  rr_arbiter #(
    .N     (NUM_FIFO),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i       (elig),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    pack32_d = pack32_q;
    tile_d   = tile_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    src_d    = src_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_CLR;
          pack32_d = pack32_i;
          tile_d   = tile_words_i;
          cnt_d    = '0;
        end
      end
      ST_CLR: begin
        ptr_d   = '0;
        state_d = (tile_q == '0) ? ST_DONE : ST_ARB;
      end
      ST_ARB: begin
        if (gnt_valid) begin
          src_d   = gnt_idx;
          ptr_d   = gnt_idx + IDX_W'(1);
          state_d = ST_CAP;
        end
      end
      ST_CAP: begin
        // FIFO pop data is registered, so it is valid the cycle after the strobe.
        data_d  = fifo_word[src_q];
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready_i) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == tile_q) ? ST_DONE : ST_ARB;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pack32_q <= 1'b0;
      tile_q   <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      src_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      pack32_q <= pack32_d;
      tile_q   <= tile_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      src_q    <= src_d;
      data_q   <= data_d;
    end
  end

  assign fifo_pop_en_o  = (state_q == ST_ARB) ? gnt : '0;
  assign fifo_pop_mod_o = pack32_q;
  assign fifo_reset_o   = (state_q == ST_CLR);
  assign out_valid_o    = (state_q == ST_SEND);
  assign out_data_o     = data_q;
  assign out_src_o      = src_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);

`ifdef OPSUM_DRAIN_ARB_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_CLR) begin
      stall_d = '0;
    end else if (state_q == ST_SEND && !out_ready_i && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: doc/opsum_drain_arb.md
OPSUM_DRAIN_ARB -- requirements
Module: opsum_drain_arb

Interface
REQ-001 The block SHALL have parameter NUM_FIFO, default 4, meaning number of opsum FIFOs drained (power of two, 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the tile word counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port start_i  input  1  begin a drain tile (pulse).
REQ-006 The block SHALL have port pack32_i  input  1  0: 16-bit pops, 1: 32-bit pops; sampled on start.
REQ-007 The block SHALL have port tile_words_i  input  CNT_W  output words in the tile; sampled on start.
REQ-008 The block SHALL have port fifo_full_i  input  NUM_FIFO  per-FIFO full flags.
REQ-009 The block SHALL have port fifo_empty_i  input  NUM_FIFO  per-FIFO empty flags.
REQ-010 The block SHALL have port fifo_data_i  input  NUM_FIFO*32  per-FIFO registered pop data, FIFO k at bits [32k+31:32k].
REQ-011 The block SHALL have port fifo_pop_en_o  output  NUM_FIFO  one-hot pop strobe.
REQ-012 The block SHALL have port fifo_pop_mod_o  output  1  pop width to all FIFOs (latched pack32).
REQ-013 The block SHALL have port fifo_reset_o  output  1  synchronous clear to all FIFOs.
REQ-014 The block SHALL have ports out_valid_o  output  1, out_ready_i  input  1, out_data_o  output  32, and out_src_o  output  $clog2(NUM_FIFO); together these form the downstream word handshake and the source FIFO index.
REQ-015 The block SHALL have ports busy_o  output  1  (tile in progress) and done_o  output  1  (one-cycle tile completion pulse).

Function
REQ-016 The block SHALL implement FSM states IDLE, CLR, ARB, CAP, SEND, DONE.
REQ-017 In IDLE, start_i=1 SHALL go to CLR, latch pack32_i and tile_words_i, and clear the word counter; start_i outside IDLE SHALL be ignored.
REQ-018 CLR SHALL assert fifo_reset_o for exactly one cycle, then go to DONE if the latched tile_words is 0, else go to ARB.
REQ-019 FIFO k SHALL be eligible when fifo_full_i[k]=1 in pack32 mode, or when fifo_empty_i[k]=0 in 16-bit mode.
REQ-020 ARB SHALL grant round-robin, searching from the index after the last grant (index 0 after reset and after CLR); with no eligible FIFO it SHALL stay in ARB with pop strobes low.
REQ-021 On a grant, fifo_pop_en_o SHALL be one-hot for exactly one cycle, the granted index SHALL be registered to out_src_o, and the FSM SHALL go to CAP.
REQ-022 CAP (one cycle after the pop) SHALL capture fifo_data_i of the granted FIFO into out_data_o and go to SEND; pop-to-out_valid_o latency SHALL be 2 cycles.
REQ-023 In SEND, out_valid_o=1 and out_data_o/out_src_o SHALL be held stable until out_ready_i=1.
REQ-024 On the SEND handshake the counter SHALL increment; if the new count equals tile_words, go to DONE, else go to ARB.
REQ-025 DONE SHALL pulse done_o for one cycle and return to IDLE.
REQ-026 busy_o SHALL be 1 in every state except IDLE.
REQ-027 fifo_pop_mod_o SHALL equal the latched pack32 value at all times.

Reset
REQ-028 rst=1 SHALL force IDLE immediately, including mid-tile.
REQ-029 Under reset, all outputs SHALL be 0, the counter SHALL be 0, and the RR pointer SHALL be 0.
REQ-030 A reset SHALL NOT generate fifo_reset_o; FIFOs are reset by their own reset.

Configuration
REQ-031 With macro OPSUM_DRAIN_ARB_PERF_EN defined, the block SHALL add output stall_cnt_o [31:0], which counts cycles in SEND with out_ready_i=0, clears in CLR, and saturates at all-ones.
REQ-032 Without OPSUM_DRAIN_ARB_PERF_EN, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-033 Package opsum_drain_arb_pkg SHALL hold the FSM state enum, the NUM_FIFO and CNT_W defaults, and the 32-bit data width constant.
REQ-034 Round-robin grant logic SHALL be a sub-module rr_arbiter (request vector and pointer in, one-hot grant plus index out).

Verification
REQ-035 NUM_FIFO=4, 16-bit mode, tile_words=4, FIFO0 and FIFO2 non-empty -> grants in order 0,2,0,2; out_src_o sequence 0,2,0,2; done_o pulses after the 4th handshake.
REQ-036 pack32 mode, FIFO1 holding 3 entries, then a 4th pushed -> no pop while 3 entries; pop_mod=1 to FIFO1 only after full=1; out_data_o={mem1,mem0}.
REQ-037 out_ready_i held low for 5 cycles in SEND -> out_valid_o and out_data_o stable, no further pops, stall_cnt_o=5 when PERF_EN is defined.
REQ-038 start_i with tile_words=0 -> fifo_reset_o for 1 cycle, done_o pulses 2 cycles after start, no pops.
REQ-039 rst asserted in CAP -> next edge IDLE, all outputs 0; a later start_i drains starting from FIFO0.
REQ-040 start_i pulsed while busy_o=1 -> ignored; latched tile_words and pack32 unchanged.
